// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC micro-rotation engine: one shift-add rotation per clock on a shared
// x/y/z datapath, with the angle taken from an external arctangent ROM.
module cordic_iter_engine #(
    parameter int BIT_WIDTH  = 64,
    parameter int ITERATIONS = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode_bit,
    input  logic [BIT_WIDTH-1:0]  x_input,
    input  logic [BIT_WIDTH-1:0]  y_input,
    input  logic [BIT_WIDTH-1:0]  z_input,
    output logic [ADDR_WIDTH-1:0] atan_addr,
    input  logic [BIT_WIDTH-1:0]  atan_data,
    output logic                  busy,
    output logic                  done,
    output logic [BIT_WIDTH-1:0]  x_output,
    output logic [BIT_WIDTH-1:0]  y_output,
    output logic [BIT_WIDTH-1:0]  z_output
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                       state_q;
    logic [ADDR_WIDTH-1:0]        iter_q;
    logic                         mode_q;
    logic                         busy_q;
    logic                         done_q;
    logic signed [BIT_WIDTH-1:0]  x_q, y_q, z_q;
    logic signed [BIT_WIDTH-1:0]  x_d, y_d, z_d;
    logic signed [BIT_WIDTH-1:0]  x_sh, y_sh;
    logic                         dir_cw;
    logic                         last_iter;

    assign last_iter = (iter_q == ADDR_WIDTH'(ITERATIONS - 1));

    // Direction comes from the pre-update registers; both shifts use pre-update values.
    always_comb begin
        dir_cw = mode_q ? ~y_q[BIT_WIDTH-1] : z_q[BIT_WIDTH-1];
        x_sh   = x_q >>> iter_q;
        y_sh   = y_q >>> iter_q;
        if (dir_cw) begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + $signed(atan_data);
        end else begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - $signed(atan_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            iter_q  <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        x_q     <= x_input;
                        y_q     <= y_input;
                        z_q     <= z_input;
                        mode_q  <= mode_bit;
                        iter_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    x_q    <= x_d;
                    y_q    <= y_d;
                    z_q    <= z_d;
                    iter_q <= iter_q + ADDR_WIDTH'(1);
                    if (last_iter) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign atan_addr = iter_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign x_output  = x_q;
    assign y_output  = y_q;
    assign z_output  = z_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Directed bench for cordic_iter_engine (16-bit, 4 iterations) with a scoreboard of
// model results pushed at each start and popped on each done pulse.
module tb_cordic_iter_engine;

    localparam int BW = 16;
    localparam int IT = 4;
    localparam int AW = 2;

    typedef struct packed {
        logic [BW-1:0] x;
        logic [BW-1:0] y;
        logic [BW-1:0] z;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode_bit;
    logic [BW-1:0] x_input, y_input, z_input;
    logic [AW-1:0] atan_addr;
    logic [BW-1:0] atan_data;
    logic          busy, done;
    logic [BW-1:0] x_output, y_output, z_output;

    res_t exp_q[$];
    res_t last_exp;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] rom_lookup(input logic [AW-1:0] a);
        case (a)
            2'd0:    return 16'd6434;
            2'd1:    return 16'd3798;
            2'd2:    return 16'd2007;
            default: return 16'd1019;
        endcase
    endfunction

    assign atan_data = rom_lookup(atan_addr);

    cordic_iter_engine #(
        .BIT_WIDTH (BW),
        .ITERATIONS(IT),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode_bit (mode_bit),
        .x_input  (x_input),
        .y_input  (y_input),
        .z_input  (z_input),
        .atan_addr(atan_addr),
        .atan_data(atan_data),
        .busy     (busy),
        .done     (done),
        .x_output (x_output),
        .y_output (y_output),
        .z_output (z_output)
    );

    function automatic res_t model(input logic [BW-1:0] xi, input logic [BW-1:0] yi,
                                   input logic [BW-1:0] zi, input logic m);
        logic signed [BW-1:0] x, y, z, xs, ys;
        logic d;
        res_t r;
        x = xi;
        y = yi;
        z = zi;
        for (int i = 0; i < IT; i++) begin
            d  = m ? ~y[BW-1] : z[BW-1];
            xs = x >>> i;
            ys = y >>> i;
            if (d) begin
                x = x + ys;
                y = y - xs;
                z = z + rom_lookup(AW'(i));
            end else begin
                x = x - ys;
                y = y + xs;
                z = z - rom_lookup(AW'(i));
            end
        end
        r.x = x;
        r.y = y;
        r.z = z;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        x_input  = BW'($urandom);
        y_input  = BW'($urandom);
        z_input  = BW'($urandom);
        mode_bit = 1'($urandom);
    endtask

    // Drives one start through the load edge, then scrambles the operand inputs.
    task automatic launch(input logic [BW-1:0] xi, input logic [BW-1:0] yi,
                          input logic [BW-1:0] zi, input logic m);
        x_input  = xi;
        y_input  = yi;
        z_input  = zi;
        mode_bit = m;
        start    = 1'b1;
        exp_q.push_back(model(xi, yi, zi, m));
        tick();
        start = 1'b0;
        scramble_inputs();
    endtask

    task automatic run_and_check(input string tag, input int addr0, input int edges0);
        int   edges = edges0;
        int   addr_i = addr0;
        int   busy_cycles = 0;
        bit   seen = 1'b0;
        res_t e;
        for (int n = 0; n < 40 && !seen; n++) begin
            if (busy) begin
                check({tag, " atan_addr"}, atan_addr, addr_i);
                addr_i++;
                busy_cycles++;
            end
            if (done) seen = 1'b1;
            else begin
                tick();
                edges++;
            end
        end
        check({tag, " done_seen"}, seen, 1);
        if (seen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " x"}, x_output, e.x);
            check({tag, " y"}, y_output, e.y);
            check({tag, " z"}, z_output, e.z);
            check({tag, " start_to_done_edges"}, edges, IT + 1);
            check({tag, " busy_cycles"}, busy_cycles, IT - addr0);
            check({tag, " busy_at_done"}, busy, 0);
            last_exp = e;
            tick();
            check({tag, " done_pulse_width"}, done, 0);
        end else begin
            check({tag, " scoreboard_nonempty"}, exp_q.size(), 1);
        end
    endtask

    initial begin
        int prev_done;
        int ndone;
        int bcount;
        res_t e;

        rst   = 1'b1;
        start = 1'b0;
        scramble_inputs();
        tick();
        tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset x", x_output, 0);
        check("reset y", y_output, 0);
        check("reset z", z_output, 0);
        check("reset addr", atan_addr, 0);
        rst = 1'b0;
        tick();
        check("idle busy", busy, 0);
        check("idle addr", atan_addr, 0);

        // Rotation case
        launch(16'd8192, 16'd0, 16'd0, 1'b0);
        check("rot loaded x", x_output, 16'd8192);
        run_and_check("rot", 0, 1);
        check("rot const x", x_output, 16'd13440);
        check("rot const y", y_output, 16'hFD80);
        check("rot const z", z_output, 16'd390);

        // Vectoring case
        launch(16'd8192, 16'd8192, 16'd0, 1'b1);
        run_and_check("vec", 0, 1);
        check("vec const x", x_output, 16'd18944);
        check("vec const y", y_output, 16'hF900);
        check("vec const z", z_output, 16'd7206);

        // Start held high: one accept every IT+2 cycles
        repeat (3) exp_q.push_back(model(16'd8192, 16'd0, 16'd0, 1'b0));
        x_input   = 16'd8192;
        y_input   = 16'd0;
        z_input   = 16'd0;
        mode_bit  = 1'b0;
        start     = 1'b1;
        prev_done = 0;
        ndone     = 0;
        bcount    = 0;
        for (int t = 1; t <= 17; t++) begin
            tick();
            if (busy) bcount++;
            if (done) begin
                if (prev_done > 0) check("held start spacing", t - prev_done, IT + 2);
                prev_done = t;
                ndone++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("held x", x_output, e.x);
                    check("held y", y_output, e.y);
                    check("held z", z_output, e.z);
                    last_exp = e;
                end
            end
        end
        start = 1'b0;
        check("held done count", ndone, 3);
        check("held busy cycles", bcount, 3 * IT);
        repeat (3) tick();
        check("held busy after", busy, 0);
        check("held scoreboard empty", exp_q.size(), 0);

        // Idle hold: inputs wiggle without start
        for (int n = 0; n < 10; n++) begin
            scramble_inputs();
            tick();
            check("hold x", x_output, last_exp.x);
            check("hold y", y_output, last_exp.y);
            check("hold z", z_output, last_exp.z);
            check("hold busy", busy, 0);
            check("hold done", done, 0);
        end

        // Reset during the second RUN cycle
        launch(16'd8192, 16'd0, 16'd0, 1'b0);
        tick();
        check("abort busy before rst", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort x", x_output, 0);
        check("abort y", y_output, 0);
        check("abort z", z_output, 0);
        check("abort addr", atan_addr, 0);
        for (int n = 0; n < 8; n++) begin
            tick();
            check("abort no done", done, 0);
        end
        launch(16'd8192, 16'd0, 16'd0, 1'b0);
        run_and_check("rot after abort", 0, 1);
        check("rot after abort const x", x_output, 16'd13440);

        // Wrap-around without saturation
        launch(16'h7FFF, 16'h7FFF, 16'h0000, 1'b1);
        tick();
        check("wrap iter0 x", x_output, 16'hFFFE);
        check("wrap iter0 y", y_output, 16'h0000);
        run_and_check("wrap", 1, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_iter_engine.md
# cordic_iter_engine

Iterative CORDIC micro-rotation engine. It consumes one (x, y, z, mode) operand set and performs ITERATIONS shift-add micro-rotations, one per clock, on a single shared datapath. It selects the rotation direction each cycle from the current sign bits and adds or subtracts the angle from an external arctangent ROM. It sits between the operand front end and the gain-compensation/output stage of the CORDIC datapath.

## Interface
Parameters:
- BIT_WIDTH, 64, width of the two's-complement x, y and z datapaths.
- ITERATIONS, 32, number of micro-rotations per operation; must satisfy 1 <= ITERATIONS <= BIT_WIDTH.
- ADDR_WIDTH, 6, width of the iteration counter and atan_addr; must satisfy 2**ADDR_WIDTH >= ITERATIONS.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  start request; sampled only in state IDLE.
- mode_bit  input  1  0 = rotation, 1 = vectoring; captured with the operands.
- x_input, y_input, z_input  input  BIT_WIDTH each  operands, captured on an accepted start.
- atan_addr  output  ADDR_WIDTH  current iteration index i, driven to the ROM.
- atan_data  input  BIT_WIDTH  atan(2^-i) in z format; combinational from atan_addr, valid in the same cycle.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when results are final.
- x_output, y_output, z_output  output  BIT_WIDTH each  working registers; final after done, held until the next accepted start.

## Operation
- States:
  - IDLE: waits for start.
  - RUN: performs iterations.
  - DONE: single cycle, done=1.
- IDLE with start=1:
  - Load x/y/z registers with the inputs, latch mode_bit, clear the counter i to 0, go to RUN.
  - start=0 in IDLE: stay in IDLE.
- Direction d, evaluated each RUN cycle from the current register values:
  - Rotation: d = z[MSB].
  - Vectoring: d = ~y[MSB].
- d=1 (clockwise) update:
  - x' = x + (y>>>i)
  - y' = y - (x>>>i)
  - z' = z + atan_data
- d=0 update:
  - x' = x - (y>>>i)
  - y' = y + (x>>>i)
  - z' = z - atan_data
- Arithmetic rules:
  - >>> is an arithmetic shift of the pre-update values.
  - Add/subtract wraps modulo 2**BIT_WIDTH; no saturation, no overflow flag.
  - No gain compensation in this block.
- Counter: after each RUN cycle, i increments. On the cycle that processes i = ITERATIONS-1, go to DONE.
- DONE: done=1, busy=0, registers unchanged, then go to IDLE.
- start is ignored in RUN and DONE; there is no queuing. The operand inputs are ignored except in the cycle a start is accepted.
- atan_addr = i in every state. It holds 0 in IDLE after reset or after a load.
- rst (any state, including mid-RUN):
  - Next state IDLE; i=0; busy=0; done=0.
  - x/y/z outputs = 0; atan_addr = 0.
  - The aborted operation produces no done.

## Timing
- Reset values: busy=0, done=0, x_output=y_output=z_output=0, atan_addr=0, state IDLE.
- Start accepted at edge k (start=1 in IDLE):
  - Load at edge k.
  - Iterations 0..ITERATIONS-1 occur at edges k+1 .. k+ITERATIONS.
  - done=1 during the cycle after edge k+ITERATIONS.
- busy is high for exactly ITERATIONS cycles.
- Minimum start-to-start spacing is ITERATIONS+2 cycles. A start held high through DONE is accepted in the following IDLE cycle.
- atan_data is sampled at the same edge that updates z.
- rst has priority over start when both are high.

## Test plan
The bench runs BIT_WIDTH=16, ITERATIONS=4, ADDR_WIDTH=2. The ROM model returns {6434, 3798, 2007, 1019} for i = 0..3.
- Rotation: x=8192, y=0, z=0, mode=0, start pulse -> after 4 busy cycles, done pulse; x=13440, y=-640, z=390; done exactly 5 edges after start.
- Vectoring: x=8192, y=8192, z=0, mode=1 -> x=18944, y=-1792, z=7206; atan_addr sequence 0, 1, 2, 3 during RUN.
- Start held high continuously -> a new operation is accepted only every 6 cycles; start pulses during RUN do not alter results or extend busy.
- Reset asserted at the 2nd RUN cycle -> next cycle busy=0, all outputs 0, no done pulse; a following start runs the normal rotation case correctly.
- Wrap-around: x=0x7FFF, y=0x7FFF, z=0, mode=1 -> after iteration 0, x=0xFFFE and y=0x0000 (no saturation); check the final values against the bit-accurate model.
- Idle hold: after done, change the inputs with start=0 for 10 cycles -> outputs stay unchanged and busy/done stay 0.
